// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared state codes and constants for the SRAM controller
package sram_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_WR_LO = 3'd1;
  localparam state_t S_WR_HI = 3'd2;
  localparam state_t S_RD_LO = 3'd3;
  localparam state_t S_RD_HI = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  localparam int unsigned DEFAULT_ADDR_BASE = 1024;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - loadable down-counter that flags the last cycle of a phase
module sram_phase_timer #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_last
);

  localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // Loaded on the edge that enters a phase, so zero marks its final cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(WAIT_CYCLES - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - MEM-stage 32-bit word access over a 16-bit async SRAM in two timed halves
// Defining SRAM_RANGE_CHECK_EN adds addr_err and rejects misaligned or out-of-range requests.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = DEFAULT_ADDR_BASE,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned SRAM_DW     = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_W_EN,
  input  logic               MEM_R_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
`ifdef SRAM_RANGE_CHECK_EN
  ,
  output logic               addr_err
`endif
);

  state_t             r_state;
  logic [31:0]        r_rdata;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [SRAM_DW-1:0] r_dq_out;
  logic               r_dq_oe;
  logic               r_we_n;
  logic               r_oe_n;

  logic [31:0]        w_offset;
  logic [SRAM_AW-2:0] w_word;
  logic               w_req;
  logic               w_err;
  logic               w_last;
  logic               w_phase_load;
  logic               w_unused;

  assign w_offset = address - ADDR_BASE;
  assign w_word   = w_offset[SRAM_AW:2];
  assign w_req    = MEM_W_EN | MEM_R_EN;
  assign w_unused = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};

`ifdef SRAM_RANGE_CHECK_EN
  logic r_addr_err;

  // Word index out of range is equivalent to any offset bit above the used slice being set.
  assign w_err = (address < ADDR_BASE) || (address[1:0] != 2'b00) ||
                 (w_offset[31:SRAM_AW+1] != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= (r_state == S_IDLE) && w_req && w_err;
    end
  end

  assign addr_err = r_addr_err;
`else
  assign w_err = 1'b0;
`endif

  assign w_phase_load = ((r_state == S_IDLE) && w_req && !w_err) ||
                        (((r_state == S_WR_LO) || (r_state == S_RD_LO)) && w_last);

  sram_phase_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_phase_load),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && w_err) begin
            r_state <= S_DONE;
            if (!MEM_W_EN) r_rdata <= '0;
          end else if (MEM_W_EN) begin
            r_state     <= S_WR_LO;
            r_sram_addr <= {w_word, HALF_LO};
            r_dq_out    <= wdata[SRAM_DW-1:0];
            r_dq_oe     <= 1'b1;
            r_we_n      <= 1'b0;
          end else if (MEM_R_EN) begin
            r_state     <= S_RD_LO;
            r_sram_addr <= {w_word, HALF_LO};
            r_oe_n      <= 1'b0;
          end
        end
        S_WR_LO: begin
          if (w_last) begin
            r_state     <= S_WR_HI;
            r_sram_addr <= {w_word, HALF_HI};
            r_dq_out    <= wdata[2*SRAM_DW-1:SRAM_DW];
          end
        end
        S_WR_HI: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_dq_oe <= 1'b0;
            r_we_n  <= 1'b1;
          end
        end
        S_RD_LO: begin
          if (w_last) begin
            r_state             <= S_RD_HI;
            r_rdata[15:0]       <= sram_dq_in;
            r_sram_addr         <= {w_word, HALF_HI};
          end
        end
        S_RD_HI: begin
          if (w_last) begin
            r_state        <= S_DONE;
            r_rdata[31:16] <= sram_dq_in;
            r_oe_n         <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready = ((r_state == S_IDLE) && !MEM_W_EN && !MEM_R_EN) || (r_state == S_DONE);

  assign rdata       = r_rdata;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_we_n   = r_we_n;
  assign sram_oe_n   = r_oe_n;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - randomized self-checking bench for sram_controller with a word-level reference model
module tb_sram_controller;

  localparam int W       = 2;
  localparam int AW      = 18;
  localparam int NWORDS  = 1 << (AW - 1);
  localparam int BASE    = 1024;

  logic        clk;
  logic        rst;
  logic        MEM_W_EN;
  logic        MEM_R_EN;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [AW-1:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;
`ifdef SRAM_RANGE_CHECK_EN
  logic        addr_err;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] smem [int];
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rdata = 32'h0;

  sram_controller #(
    .ADDR_BASE  (BASE),
    .SRAM_AW    (AW),
    .SRAM_DW    (16),
    .WAIT_CYCLES(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_W_EN   (MEM_W_EN),
    .MEM_R_EN   (MEM_R_EN),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
`ifdef SRAM_RANGE_CHECK_EN
    ,
    .addr_err   (addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM model: writes and read data settle mid-cycle.
  always @(negedge clk) begin
    if (!sram_we_n && sram_dq_oe) smem[int'(sram_addr)] = sram_dq_out;
    sram_dq_in = smem.exists(int'(sram_addr)) ? smem[int'(sram_addr)] : 16'h0;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return int'((off >> 2) % 32'(NWORDS));
  endfunction

  function automatic bit is_err(input logic [31:0] a);
`ifdef SRAM_RANGE_CHECK_EN
    return (a < 32'(BASE)) || (a[1:0] != 2'b00) || (((a - 32'(BASE)) >> 2) >= 32'(NWORDS));
`else
    return (a === 32'hx);
`endif
  endfunction

  task automatic go_idle();
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'b0, ready}, 32'd1);
  endtask

  // Starts at a negedge: in IDLE (b2b=0) or in the previous DONE (b2b=1); ends at the DONE negedge.
  task automatic access(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] wd, input bit b2b);
    int lowcnt = 0;
    int we_cyc = 0;
    int lo_hit = 0;
    int hi_hit = 0;
    int oe_cyc = 0;
    int oe_rd  = 0;
    int word;
    bit err;
    word = word_of(a);
    err  = is_err(a);
    MEM_W_EN = we;
    MEM_R_EN = re;
    address  = a;
    wdata    = wd;
    if (b2b) @(negedge clk);
    else #1;
    while (!ready && lowcnt < 64) begin
      if (!sram_we_n) begin
        we_cyc++;
        if (int'(sram_addr) == 2*word && sram_dq_out == wd[15:0] && sram_dq_oe) lo_hit++;
        if (int'(sram_addr) == 2*word+1 && sram_dq_out == wd[31:16] && sram_dq_oe) hi_hit++;
      end
      if (!sram_oe_n) oe_cyc++;
      if (sram_dq_oe && !we) oe_rd++;
      lowcnt++;
      @(negedge clk);
    end
    if (we && !err) ref_mem[word] = wd;
    else if (re && !we) ref_rdata = err ? 32'h0 : (ref_mem.exists(word) ? ref_mem[word] : 32'h0);
    chk("ready_low", lowcnt, err ? 1 : 1 + 2*W);
    chk("we_cycles", we_cyc, (we && !err) ? 2*W : 0);
    if (we && !err) begin
      chk("wr_lo", lo_hit, W);
      chk("wr_hi", hi_hit, W);
    end
    if (!we) begin
      chk("oe_cycles", oe_cyc, (re && !err) ? 2*W : 0);
      chk("rd_dq_oe", oe_rd, 0);
    end
    chk("rdata", rdata, ref_rdata);
`ifdef SRAM_RANGE_CHECK_EN
    chk("addr_err", {31'b0, addr_err}, {31'b0, err});
`endif
  endtask

  initial begin
    logic [31:0] a;
    int k;
    int rw;
    bit b2b;
    rst = 1'b1;
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b0;
    address = 32'h0;
    wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
    chk("rst_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_dq_out", {16'h0, sram_dq_out}, 32'h0);
    rst = 1'b0;

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
    go_idle();
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
    chk("load_1024", rdata, 32'hDEADBEEF);
    go_idle();
    access(1'b1, 1'b0, 32'd1032, 32'h12345678, 1'b0);
    access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b1);
    chk("b2b_load", rdata, 32'h12345678);
    go_idle();
    access(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, 1'b0);
    chk("both_rdata", rdata, 32'h12345678);
    go_idle();

    MEM_W_EN = 1'b1;
    address  = 32'd1036;
    wdata    = 32'hA5A55A5A;
    repeat (3) @(negedge clk);
    chk("pre_rst_we_n", {31'b0, sram_we_n}, 32'd0);
    chk("pre_rst_addr", 32'(sram_addr), 32'd7);
    rst = 1'b1;
    MEM_W_EN = 1'b0;
    @(negedge clk);
    chk("mid_rst_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("mid_rst_ready", {31'b0, ready}, 32'd1);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
    rst = 1'b0;
    ref_rdata = 32'h0;
    ref_mem.delete(word_of(32'd1036));

    access(1'b1, 1'b0, 32'd1036, 32'h0BADF00D, 1'b0);
    go_idle();
    access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0);
    chk("reread_1036", rdata, 32'h0BADF00D);
`ifdef SRAM_RANGE_CHECK_EN
    go_idle();
    access(1'b0, 1'b1, 32'd1000, 32'h0, 1'b0);
    chk("err_rd_rdata", rdata, 32'h0);
    go_idle();
    access(1'b1, 1'b0, 32'd1026, 32'h11112222, 1'b0);
`endif

    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 15);
      if (k < 12)       a = 32'(BASE) + 32'(4 * $urandom_range(0, 31));
      else if (k < 14)  a = 32'(BASE) + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
      else if (k == 14) a = 32'($urandom_range(0, BASE - 1));
      else              a = 32'(BASE) + 32'(4 * NWORDS) + 32'(4 * $urandom_range(0, 3));
      rw  = $urandom_range(0, 8);
      b2b = bit'($urandom_range(0, 1));
      if (!b2b) go_idle();
      access(rw < 4 || rw == 8, rw >= 4, a, $urandom, b2b);
    end
    go_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
